// File: rtl/shift_pkg.sv
// Shared definitions for the shift unit: the 2-bit mode encoding that the ALU
// decoder also drives onto in_mode.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_mode_e;

endpackage : shift_pkg

// File: rtl/shift_level.sv
// One level of the logarithmic shifter: conditionally moves the word by DIST
// bit positions in the direction and with the fill selected by mode.
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] in_data,
    input  logic             en,
    input  shift_mode_e      mode,
    input  logic             sign,
    output logic [WIDTH-1:0] out_data
);

    // NOTE: out_data gets a default before any branch so no path leaves it
    // unassigned; that is what keeps combinational blocks free of latches.
    always_comb begin
        out_data = in_data;
        if (en) begin
            case (mode)
                SHIFT_SLL: out_data = {in_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
                SHIFT_SRL: out_data = {{DIST{1'b0}}, in_data[WIDTH-1:DIST]};
                SHIFT_SRA: out_data = {{DIST{sign}}, in_data[WIDTH-1:DIST]};
                SHIFT_ROR: out_data = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
                default:   out_data = in_data;
            endcase
        end
    end

endmodule : shift_level

// File: rtl/shift_unit.sv
// Two-stage pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready
// handshakes on both sides and a tag carried alongside each operation.
module shift_unit
    import shift_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  TAG_W = 5,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    // Stage 1 resolves the low half of the levels, stage 2 the rest.
    localparam int L1 = (SHW + 1) / 2;
    localparam int L2 = SHW - L1;

    shift_mode_e in_mode_e;
    assign in_mode_e = shift_mode_e'(in_mode);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [L2-1:0]    s1_shamt_q, s1_shamt_d;
    shift_mode_e      s1_mode_q,  s1_mode_d;
    logic             s1_sign_q,  s1_sign_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q,  s2_data_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
    logic             s2_zero_q,  s2_zero_d;

    logic             s1_load, s2_load;

    logic [WIDTH-1:0] s1_chain [0:L1];
    logic [WIDTH-1:0] s2_chain [0:L2];

    assign s1_chain[0] = in_data;
    for (genvar i = 0; i < L1; i++) begin : g_stage1
        shift_level #(.WIDTH(WIDTH), .DIST(1 << i)) u_level (
            .in_data  (s1_chain[i]),
            .en       (in_shamt[i]),
            .mode     (in_mode_e),
            .sign     (in_data[WIDTH-1]),
            .out_data (s1_chain[i+1])
        );
    end

    // The captured operand sign drives SRA fill, since the partial result's
    // MSB is not the operand's sign once ROR/SRL levels have run.
    assign s2_chain[0] = s1_data_q;
    for (genvar i = 0; i < L2; i++) begin : g_stage2
        shift_level #(.WIDTH(WIDTH), .DIST(1 << (L1 + i))) u_level (
            .in_data  (s2_chain[i]),
            .en       (s1_shamt_q[i]),
            .mode     (s1_mode_q),
            .sign     (s1_sign_q),
            .out_data (s2_chain[i+1])
        );
    end

    always_comb begin
        s2_load    = !s2_valid_q || out_ready;
        s1_load    = !s1_valid_q || s2_load;

        s1_valid_d = s1_load ? in_valid   : s1_valid_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

        s1_data_d  = s1_data_q;
        s1_shamt_d = s1_shamt_q;
        s1_mode_d  = s1_mode_q;
        s1_sign_d  = s1_sign_q;
        s1_tag_d   = s1_tag_q;
        if (s1_load && in_valid) begin
            s1_data_d  = s1_chain[L1];
            s1_shamt_d = in_shamt[SHW-1:L1];
            s1_mode_d  = in_mode_e;
            s1_sign_d  = in_data[WIDTH-1];
            s1_tag_d   = in_tag;
        end

        s2_data_d = s2_data_q;
        s2_tag_d  = s2_tag_q;
        s2_zero_d = s2_zero_q;
        if (s2_load && s1_valid_q) begin
            s2_data_d = s2_chain[L2];
            s2_tag_d  = s1_tag_q;
            s2_zero_d = (s2_chain[L2] == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // NOTE: payload flops are deliberately left out of reset; only the valid
    // flags qualify them, so resetting wide data buys nothing.
    always_ff @(posedge clock) begin
        s1_data_q  <= s1_data_d;
        s1_shamt_q <= s1_shamt_d;
        s1_mode_q  <= s1_mode_d;
        s1_sign_q  <= s1_sign_d;
        s1_tag_q   <= s1_tag_d;
        s2_data_q  <= s2_data_d;
        s2_tag_q   <= s2_tag_d;
        s2_zero_q  <= s2_zero_d;
    end

    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign out_zero  = s2_zero_q;

endmodule : shift_unit

// File: tb/tb_shift_unit.sv
// Directed self-checking bench for shift_unit at WIDTH=32: modes, boundaries,
// back-to-back streaming, backpressure and mid-operation reset.
module tb_shift_unit;
    import shift_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int SHW   = 5;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    int tests_run    = 0;
    int tests_failed = 0;

    shift_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    always #5 clock = ~clock;

    task automatic drive_op(input logic [31:0] d, input logic [4:0] sh,
                            input logic [1:0] m, input logic [4:0] t);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_mode  = m;
        in_tag   = t;
    endtask

    // Offers one op with out_ready high and returns what was seen at the
    // acceptance cycle, one cycle later and two cycles later.
    task automatic run_single(input logic [31:0] d, input logic [4:0] sh,
                              input logic [1:0] m, input logic [4:0] t,
                              output logic [2:0] timing, output logic [31:0] od,
                              output logic [4:0] ot, output logic oz);
        @(negedge clock);
        out_ready = 1'b1;
        drive_op(d, sh, m, t);
        #1 timing[2] = in_ready;
        @(negedge clock);
        in_valid  = 1'b0;
        timing[1] = out_valid;
        @(negedge clock);
        timing[0] = out_valid;
        od = out_data;
        ot = out_tag;
        oz = out_zero;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_modes();
        logic [1:0]  modes [4] = '{SHIFT_SRA, SHIFT_SRL, SHIFT_SLL, SHIFT_ROR};
        logic [31:0] exp   [4] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0010, 32'h1800_0000};
        logic [2:0]  timing;
        logic [31:0] od;
        logic [4:0]  ot;
        logic        oz;
        for (int i = 0; i < 4; i++) begin
            run_single(32'h8000_0001, 5'd4, modes[i], 5'(i + 4), timing, od, ot, oz);
            tests_run++;
            if (timing !== 3'b101) begin
                tests_failed++;
                $display("FAIL modes[%0d] latency ready/v1/v2: got %b expected 101", i, timing);
            end
            tests_run++;
            if (od !== exp[i] || ot !== 5'(i + 4) || oz !== 1'b0) begin
                tests_failed++;
                $display("FAIL modes[%0d] result: got %h tag %0d zero %b expected %h tag %0d zero 0",
                         i, od, ot, oz, exp[i], i + 4);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] din  [10] = '{32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96,
                                   32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h7FFF_FFFF,
                                   32'h8000_0000, 32'h0000_0000};
        logic [4:0]  sh   [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd1, 5'd31, 5'd31, 5'd0};
        logic [1:0]  md   [10] = '{SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR, SHIFT_SRA,
                                   SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR, SHIFT_ROR};
        logic [31:0] exp  [10] = '{32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96,
                                   32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000,
                                   32'h0000_0001, 32'h0000_0000};
        logic        expz [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  timing;
        logic [31:0] od;
        logic [4:0]  ot;
        logic        oz;
        for (int i = 0; i < 10; i++) begin
            run_single(din[i], sh[i], md[i], 5'(20 + i), timing, od, ot, oz);
            tests_run++;
            if (timing !== 3'b101 || od !== exp[i] || oz !== expz[i] || ot !== 5'(20 + i)) begin
                tests_failed++;
                $display("FAIL boundary[%0d]: got timing %b data %h zero %b tag %0d expected 101 %h %b %0d",
                         i, timing, od, oz, ot, exp[i], expz[i], 20 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] din [8] = '{32'h0000_00FF, 32'hFF00_0000, 32'hF000_0000, 32'h0000_000F,
                                 32'h1234_5678, 32'h1234_5678, 32'h4000_0000, 32'h1234_5678};
        logic [4:0]  sh  [8] = '{5'd8, 5'd16, 5'd2, 5'd2, 5'd12, 5'd20, 5'd30, 5'd16};
        logic [1:0]  md  [8] = '{SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR,
                                 SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR};
        logic [31:0] exp [8] = '{32'h0000_FF00, 32'h0000_FF00, 32'hFC00_0000, 32'hC000_0003,
                                 32'h4567_8000, 32'h0000_0123, 32'h0000_0001, 32'h5678_1234};
        for (int k = 0; k < 11; k++) begin
            @(negedge clock);
            out_ready = 1'b1;
            if (k < 2 || k == 10) begin
                tests_run++;
                if (out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b cycle %0d out_valid: got %b expected 0", k, out_valid);
                end
            end else begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== exp[k-2] || out_tag !== 5'(10 + k - 2)) begin
                    tests_failed++;
                    $display("FAIL b2b result %0d: got valid %b data %h tag %0d expected 1 %h %0d",
                             k - 2, out_valid, out_data, out_tag, exp[k-2], 10 + k - 2);
                end
            end
            if (k < 8) begin
                drive_op(din[k], sh[k], md[k], 5'(10 + k));
                #1;
                tests_run++;
                if (in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b offer %0d in_ready: got %b expected 1", k, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        int   accepted = 0;
        logic stable   = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        drive_op(32'hF0F0_F0F0, 5'd4, SHIFT_SRL, 5'd1);
        #1 if (in_ready) accepted++;
        @(negedge clock);
        drive_op(32'h0000_0003, 5'd30, SHIFT_SLL, 5'd2);
        #1 if (in_ready) accepted++;
        @(negedge clock);
        drive_op(32'h0000_00F0, 5'd8, SHIFT_ROR, 5'd3);
        #1;
        tests_run++;
        if (accepted != 2 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp accept: got %0d accepted in_ready %b expected 2 accepted in_ready 0",
                     accepted, in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h0F0F_0F0F || out_tag !== 5'd1) begin
            tests_failed++;
            $display("FAIL bp head: got valid %b data %h tag %0d expected 1 0f0f0f0f 1",
                     out_valid, out_data, out_tag);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            if (out_valid !== 1'b1 || out_data !== 32'h0F0F_0F0F || out_tag !== 5'd1 ||
                out_zero !== 1'b0 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        tests_run++;
        if (stable !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp stall hold: got stable %b expected 1", stable);
        end
        @(negedge clock);
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp release in_ready: got %b expected 1", in_ready);
        end
        @(negedge clock);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hC000_0000 || out_tag !== 5'd2) begin
            tests_failed++;
            $display("FAIL bp second: got valid %b data %h tag %0d expected 1 c0000000 2",
                     out_valid, out_data, out_tag);
        end
        @(negedge clock);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'hF000_0000 || out_tag !== 5'd3) begin
            tests_failed++;
            $display("FAIL bp third: got valid %b data %h tag %0d expected 1 f0000000 3",
                     out_valid, out_data, out_tag);
        end
        @(negedge clock);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp drained out_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_midop();
        logic        seen = 1'b0;
        logic [2:0]  timing;
        logic [31:0] od;
        logic [4:0]  ot;
        logic        oz;
        @(negedge clock);
        out_ready = 1'b0;
        drive_op(32'h0000_00FF, 5'd1, SHIFT_SLL, 5'd7);
        @(negedge clock);
        drive_op(32'h0000_00FF, 5'd2, SHIFT_SLL, 5'd8);
        @(negedge clock);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst in-flight out_valid: got %b expected 1", out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst async clear: got out_valid %b in_ready %b expected 0 1",
                     out_valid, in_ready);
        end
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst ghost result: got seen %b expected 0", seen);
        end
        run_single(32'h0000_0001, 5'd5, SHIFT_SLL, 5'd9, timing, od, ot, oz);
        tests_run++;
        if (timing !== 3'b101 || od !== 32'h0000_0020 || ot !== 5'd9) begin
            tests_failed++;
            $display("FAIL rst recovery: got timing %b data %h tag %0d expected 101 00000020 9",
                     timing, od, ot);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        test_reset();
        test_modes();
        test_boundaries();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_shift_unit
